// File: rtl/cdf_fetch_stream.sv
// cdf_fetch_stream: histogram bank fetch with tag check, credit-limited read pipe and output FIFO
//
// Ports:
//   clock, reset_n     clock and asynchronous active-low reset
//   start_i, abort_i   run request (honoured in IDLE only) and synchronous flush
//   bank_sel_i         bank captured on an accepted start
//   rd_en_o, rd_addr_o memory read strobe and address (address is 0 when idle)
//   rd_bus_i           {tag, data} returned RD_LAT cycles after rd_en_o
//   out_valid_o, out_ready_i, out_data_o, out_addr_o   ready/valid output stream
//   busy_o, done_o, tag_err_o  run status, completion pulse, sticky tag error
//
// Optional feature macro: CDF_FETCH_TAG_CHECK_EN enables the tag check; without it
// the tag bits are ignored and tag_err_o stays 0.
module cdf_fetch_stream #(
    parameter int                DATA_W  = 20,
    parameter int                TAG_W   = 16,
    parameter logic [TAG_W-1:0]  TAG_VAL = 16'hAAAA,
    parameter int                ADDR_W  = 16,
    parameter int                BINS    = 256,
    parameter int                BANK_W  = 1,
    parameter int                RD_LAT  = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [BANK_W-1:0]       bank_sel_i,
    output logic                    rd_en_o,
    output logic [ADDR_W-1:0]       rd_addr_o,
    input  logic [TAG_W+DATA_W-1:0] rd_bus_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_W-1:0]       out_data_o,
    output logic [ADDR_W-1:0]       out_addr_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    tag_err_o
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int IW    = $clog2(BINS + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic                rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d, tag_err_q, tag_err_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, base_q, base_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [RD_LAT-1:0]   pv_q;
    logic [ADDR_W-1:0]   pa_q [RD_LAT];
    logic [DATA_W-1:0]   fd_q [DEPTH];
    logic [ADDR_W-1:0]   fa_q [DEPTH];
    logic [PW-1:0]       wp_q, rp_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                push, pop, credit, bad;
    logic [DATA_W-1:0]   push_data;
    logic [ADDR_W-1:0]   bank_base;
    int                  inflight;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

`ifdef CDF_FETCH_TAG_CHECK_EN
    assign bad = rd_bus_i[TAG_W+DATA_W-1:DATA_W] != TAG_VAL;
`else
    logic unused_tag;
    assign bad        = 1'b0;
    assign unused_tag = ^{rd_bus_i[TAG_W+DATA_W-1:DATA_W], TAG_VAL};
`endif

    assign bank_base = {bank_sel_i, {(ADDR_W-BANK_W){1'b0}}};
    assign push      = pv_q[RD_LAT-1];
    assign pop       = (cnt_q != '0) && out_ready_i;
    assign push_data = bad ? '0 : rd_bus_i[DATA_W-1:0];

    always_comb begin
        inflight = 0;
        for (int i = 0; i < RD_LAT; i++) inflight += int'(pv_q[i]);
        // Everything already committed after the coming edge must leave room for one more read.
        credit    = inflight + int'(rd_en_q) + int'(cnt_q) - int'(pop) < DEPTH;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        state_d   = state_q;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        base_d    = base_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        tag_err_d = tag_err_q | (push & bad);
        case (state_q)
            IDLE: if (start_i) begin
                state_d   = FETCH;
                base_d    = bank_base;
                rd_en_d   = 1'b1;
                rd_addr_d = bank_base;
                idx_d     = IW'(1);
                tag_err_d = 1'b0;
            end
            FETCH: if (idx_q == IW'(BINS)) state_d = DRAIN;
            else if (credit) begin
                rd_en_d   = 1'b1;
                rd_addr_d = base_q + ADDR_W'(idx_q);
                idx_d     = idx_q + 1'b1;
            end
            // Look at next-cycle occupancy so done lands right after the last pop.
            DRAIN: if (cnt_d == '0 && inflight - int'(push) == 0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d   = IDLE;
            rd_en_d   = 1'b0;
            rd_addr_d = '0;
            idx_d     = '0;
            done_d    = 1'b0;
            tag_err_d = tag_err_q;
        end
        busy_d = state_d == FETCH || state_d == DRAIN;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            base_q    <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tag_err_q <= 1'b0;
            pv_q      <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < RD_LAT; i++) pa_q[i] <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fd_q[i] <= '0;
                fa_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            base_q    <= base_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tag_err_q <= tag_err_d;
            pa_q[0]   <= rd_addr_q;
            for (int i = 1; i < RD_LAT; i++) pa_q[i] <= pa_q[i-1];
            if (abort_i) begin
                pv_q  <= '0;
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
            end else begin
                pv_q  <= RD_LAT'({pv_q, rd_en_q});
                cnt_q <= cnt_d;
                if (push) begin
                    fd_q[wp_q] <= push_data;
                    fa_q[wp_q] <= pa_q[RD_LAT-1];
                    wp_q       <= nxt(wp_q);
                end
                if (pop) rp_q <= nxt(rp_q);
            end
        end
    end

    assign rd_en_o     = rd_en_q;
    assign rd_addr_o   = rd_addr_q;
    assign out_valid_o = cnt_q != '0;
    assign out_data_o  = fd_q[rp_q];
    assign out_addr_o  = fa_q[rp_q];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign tag_err_o   = tag_err_q;
endmodule
